// File: rtl/cpu_types_pkg.sv
// Shared types for the sequential ALU: operation codes, FSM states and the
// pattern returned for undefined operation codes.
package cpu_types_pkg;

   // Eleven single-cycle codes followed by the four iterative ones
   typedef enum logic [4:0] {
      OP_SLL  = 5'd0,
      OP_SRL  = 5'd1,
      OP_SRA  = 5'd2,
      OP_ADD  = 5'd3,
      OP_SUB  = 5'd4,
      OP_AND  = 5'd5,
      OP_OR   = 5'd6,
      OP_XOR  = 5'd7,
      OP_NOR  = 5'd8,
      OP_SLT  = 5'd9,
      OP_SLTU = 5'd10,
      OP_MUL  = 5'd11,
      OP_MULU = 5'd12,
      OP_DIV  = 5'd13,
      OP_DIVU = 5'd14
   } seqop_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } seq_state_t;

   localparam logic [31:0] SEQ_BAD = 32'hBADC0DE;

   // True for operations that run through the iterative datapath
   function automatic logic is_iter_op(input seqop_t o);
      return (o == OP_MUL) || (o == OP_MULU) || (o == OP_DIV) || (o == OP_DIVU);
   endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative datapath for seq_alu: one shift-add (multiply) or restoring
// shift-subtract (divide) step per cycle on unsigned magnitudes.
// Ports:
//   CLK, RST  clock, synchronous active-high reset
//   start     load magnitudes and counter (W-1) for a new operation
//   div_op    operation loaded by start is a divide
//   step      perform one iteration this cycle
//   a_mag     multiplicand / dividend magnitude
//   b_mag     multiplier / divisor magnitude
//   res_c     accumulator value after the current step
//             multiply: full 2W product; divide: {remainder, quotient}
//   last_c    current step is the final one
// Build option: SEQ_ALU_MUL_EARLY_EN ends a multiply as soon as the
// remaining multiplier bits are all zero.
module seq_alu_iter #(
   parameter int unsigned W     = 32,
   parameter int unsigned CNT_W = $clog2(W)
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           start,
   input  logic           div_op,
   input  logic           step,
   input  logic [W-1:0]   a_mag,
   input  logic [W-1:0]   b_mag,
   output logic [2*W-1:0] res_c,
   output logic           last_c
);

   logic [2*W-1:0] acc;
   logic [2*W-1:0] mcand;
   logic [W-1:0]   mplr;
   logic [CNT_W-1:0] cnt;
   logic           div_mode;

   logic [2*W-1:0] acc_step;
   logic [2*W-1:0] mcand_step;
   logic [W-1:0]   mplr_step;
   logic [W:0]     part;
   logic [W-1:0]   rem_sub;
   logic           ge;

   // One iteration: divide uses acc = {remainder, dividend/quotient}
   always_comb begin
      acc_step   = acc;
      mcand_step = mcand;
      mplr_step  = mplr;
      part       = {acc[2*W-1:W], acc[W-1]};
      ge         = part >= {1'b0, mcand[W-1:0]};
      rem_sub    = W'(part - {1'b0, mcand[W-1:0]});
      if (div_mode) begin
         if (ge) acc_step = {rem_sub, acc[W-2:0], 1'b1};
         else    acc_step = {acc[2*W-2:W], acc[W-1], acc[W-2:0], 1'b0};
      end else begin
         acc_step   = mplr[0] ? (acc + mcand) : acc;
         mcand_step = mcand << 1;
         mplr_step  = mplr >> 1;
      end
   end

   assign res_c = acc_step;

`ifdef SEQ_ALU_MUL_EARLY_EN
   assign last_c = (cnt == '0) || (!div_mode && (mplr_step == '0));
`else
   assign last_c = (cnt == '0);
`endif

   // Operand / accumulator registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         acc      <= '0;
         mcand    <= '0;
         mplr     <= '0;
         cnt      <= '0;
         div_mode <= 1'b0;
      end else if (start) begin
         div_mode <= div_op;
         cnt      <= CNT_W'(W - 1);
         if (div_op) begin
            acc   <= {W'(0), a_mag};
            mcand <= {W'(0), b_mag};
            mplr  <= '0;
         end else begin
            acc   <= '0;
            mcand <= {W'(0), a_mag};
            mplr  <= b_mag;
         end
      end else if (step) begin
         acc   <= acc_step;
         mcand <= mcand_step;
         mplr  <= mplr_step;
         cnt   <= cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential integer ALU for the execute stage. Single-cycle ops
// register their result one cycle after accept; MUL/MULU/DIV/DIVU iterate
// W cycles in seq_alu_iter and produce {out_hi, out_lo}.
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   in_valid / in_ready  request handshake (in_ready only in IDLE, no result held)
//   op, a, b             operation code (seqop_t) and operands
//   out_valid/out_ready  result handshake; result held until consumed
//   out_lo, out_hi       result/product low/quotient, product high/remainder
//   nf, zf, vf, dz       negative, zero, signed overflow, divide by zero
// Build option: SEQ_ALU_MUL_EARLY_EN (early multiply termination, see
// seq_alu_iter).
module seq_alu
   import cpu_types_pkg::*;
#(
   parameter int unsigned W     = 32,
   parameter int unsigned CNT_W = $clog2(W)
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [4:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_lo,
   output logic [W-1:0] out_hi,
   output logic         nf,
   output logic         zf,
   output logic         vf,
   output logic         dz
);

   localparam int unsigned        REPS    = (W + 31) / 32;
   localparam logic [REPS*32-1:0] BAD_REP = {REPS{SEQ_BAD}};
   localparam logic [W-1:0]       BAD_W   = BAD_REP[W-1:0];
   localparam logic [W-1:0]       MIN_W   = {1'b1, {(W-1){1'b0}}};

   seq_state_t state;
   seqop_t     op_c;

   // Per-operation facts captured at accept for the final iteration
   logic [W-1:0] a_q;
   logic         neg_q;
   logic         negr_q;
   logic         dz_q;
   logic         ovf_q;

   logic           accept_c, is_mul_c, is_div_c, sgn_c;
   logic           a_neg_c, b_neg_c, start_c, step_c, load_c;
   logic [W-1:0]   a_mag_c, b_mag_c, sum_c, dif_c;
   logic [CNT_W-1:0] shamt_c;
   logic [2*W-1:0] iter_res_c, prod_c;
   logic [W-1:0]   quo_c, rem_c;
   logic           iter_last_c;
   logic [W-1:0]   res_lo_c, res_hi_c;
   logic           res_vf_c, res_dz_c;

   assign op_c     = seqop_t'(op);
   assign accept_c = in_valid && in_ready;
   assign is_mul_c = (op_c == OP_MUL) || (op_c == OP_MULU);
   assign is_div_c = (op_c == OP_DIV) || (op_c == OP_DIVU);
   assign sgn_c    = (op_c == OP_MUL) || (op_c == OP_DIV);
   assign a_neg_c  = sgn_c && a[W-1];
   assign b_neg_c  = sgn_c && b[W-1];
   assign a_mag_c  = a_neg_c ? -a : a;
   assign b_mag_c  = b_neg_c ? -b : b;
   assign start_c  = (state == IDLE) && accept_c && is_iter_op(op_c);
   assign step_c   = (state == MUL) || (state == DIV);
   assign load_c   = ((state == IDLE) && accept_c && !is_iter_op(op_c)) ||
                     (step_c && iter_last_c);

   assign sum_c   = a + b;
   assign dif_c   = a - b;
   assign shamt_c = b[CNT_W-1:0];

   // Signed results are formed from magnitudes and corrected here
   assign prod_c = neg_q ? -iter_res_c : iter_res_c;
   assign quo_c  = iter_res_c[W-1:0];
   assign rem_c  = iter_res_c[2*W-1:W];

   seq_alu_iter #(.W(W), .CNT_W(CNT_W)) u_iter (
      .CLK    (CLK),
      .RST    (RST),
      .start  (start_c),
      .div_op (is_div_c),
      .step   (step_c),
      .a_mag  (a_mag_c),
      .b_mag  (b_mag_c),
      .res_c  (iter_res_c),
      .last_c (iter_last_c)
   );

   // Result selection: iterative finish in MUL/DIV, single-cycle op otherwise
   always_comb begin
      res_lo_c = '0;
      res_hi_c = '0;
      res_vf_c = 1'b0;
      res_dz_c = 1'b0;
      case (state)
         MUL: begin
            res_lo_c = prod_c[W-1:0];
            res_hi_c = prod_c[2*W-1:W];
         end
         DIV: begin
            if (dz_q) begin
               res_lo_c = '1;
               res_hi_c = a_q;
               res_dz_c = 1'b1;
            end else begin
               res_lo_c = neg_q  ? -quo_c : quo_c;
               res_hi_c = negr_q ? -rem_c : rem_c;
               res_vf_c = ovf_q;
            end
         end
         default: begin
            case (op_c)
               OP_SLL:  res_lo_c = a << shamt_c;
               OP_SRL:  res_lo_c = a >> shamt_c;
               OP_SRA:  res_lo_c = $unsigned($signed(a) >>> shamt_c);
               OP_ADD: begin
                  res_lo_c = sum_c;
                  res_vf_c = (a[W-1] == b[W-1]) && (sum_c[W-1] != a[W-1]);
               end
               OP_SUB: begin
                  res_lo_c = dif_c;
                  res_vf_c = (a[W-1] != b[W-1]) && (dif_c[W-1] != a[W-1]);
               end
               OP_AND:  res_lo_c = a & b;
               OP_OR:   res_lo_c = a | b;
               OP_XOR:  res_lo_c = a ^ b;
               OP_NOR:  res_lo_c = ~(a | b);
               OP_SLT:  res_lo_c = W'($signed(a) < $signed(b));
               OP_SLTU: res_lo_c = W'(a < b);
               default: res_lo_c = BAD_W;
            endcase
         end
      endcase
   end

   // Control FSM, handshake and registered outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_lo    <= '0;
         out_hi    <= '0;
         nf        <= 1'b0;
         zf        <= 1'b0;
         vf        <= 1'b0;
         dz        <= 1'b0;
         a_q       <= '0;
         neg_q     <= 1'b0;
         negr_q    <= 1'b0;
         dz_q      <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept_c) begin
                  in_ready <= 1'b0;
                  a_q      <= a;
                  neg_q    <= a_neg_c ^ b_neg_c;
                  negr_q   <= a_neg_c;
                  dz_q     <= is_div_c && (b == '0);
                  ovf_q    <= (op_c == OP_DIV) && (a == MIN_W) && (b == '1);
                  if (is_mul_c)      state <= MUL;
                  else if (is_div_c) state <= DIV;
                  else               state <= DONE;
               end
            end
            MUL, DIV: begin
               if (iter_last_c) state <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (load_c) begin
            out_valid <= 1'b1;
            out_lo    <= res_lo_c;
            out_hi    <= res_hi_c;
            nf        <= res_lo_c[W-1];
            zf        <= (res_lo_c == '0);
            vf        <= res_vf_c;
            dz        <= res_dz_c;
         end
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (W=32): a driver issues directed and random
// operations and queues the expected response from a reference model; a
// monitor pops and compares each result as the DUT presents it.
module tb_seq_alu;
   import cpu_types_pkg::*;

   localparam int unsigned W = 32;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] lo;
      logic [31:0] hi;
      logic        nf, zf, vf, dz;
      int          lat_min, lat_max;
      int          acc_cyc;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RST;
   logic        in_valid, in_ready;
   logic [4:0]  op;
   logic [31:0] a, b;
   logic        out_valid, out_ready;
   logic [31:0] out_lo, out_hi;
   logic        nf, zf, vf, dz;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   rdy_mode = 0;   // 0 random, 1 force low, 2 force high
   bit   checked  = 1'b0;

   seq_alu #(.W(W)) dut (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .out_lo(out_lo), .out_hi(out_hi), .nf(nf), .zf(zf), .vf(vf), .dz(dz)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h required=%h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Reference behaviour from plain integer arithmetic
   function automatic exp_t model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
      exp_t        e;
      longint      sx, sy, s;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      e.op = o; e.lo = '0; e.hi = '0; e.vf = 1'b0; e.dz = 1'b0;
      e.lat_min = 1; e.lat_max = 1; e.acc_cyc = 0;
      case (seqop_t'(o))
         OP_SLL:  e.lo = x << y[4:0];
         OP_SRL:  e.lo = x >> y[4:0];
         OP_SRA:  e.lo = 32'($signed(x) >>> y[4:0]);
         OP_ADD: begin
            s = sx + sy; e.lo = 32'(s); e.vf = (s > SMAX) || (s < SMIN);
         end
         OP_SUB: begin
            s = sx - sy; e.lo = 32'(s); e.vf = (s > SMAX) || (s < SMIN);
         end
         OP_AND:  e.lo = x & y;
         OP_OR:   e.lo = x | y;
         OP_XOR:  e.lo = x ^ y;
         OP_NOR:  e.lo = ~(x | y);
         OP_SLT:  e.lo = (sx < sy) ? 32'd1 : 32'd0;
         OP_SLTU: e.lo = (x < y) ? 32'd1 : 32'd0;
         OP_MUL, OP_MULU: begin
            if (seqop_t'(o) == OP_MUL) p = 64'(sx * sy);
            else                       p = 64'(x) * 64'(y);
            e.lo = p[31:0]; e.hi = p[63:32];
`ifdef SEQ_ALU_MUL_EARLY_EN
            e.lat_min = 2;
`else
            e.lat_min = 33;
`endif
            e.lat_max = 33;
         end
         OP_DIV, OP_DIVU: begin
            e.lat_min = 33; e.lat_max = 33;
            if (y == 32'd0) begin
               e.dz = 1'b1; e.lo = 32'hFFFFFFFF; e.hi = x;
            end else if (seqop_t'(o) == OP_DIVU) begin
               e.lo = x / y; e.hi = x % y;
            end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
               e.lo = 32'h80000000; e.hi = '0; e.vf = 1'b1;
            end else begin
               e.lo = 32'(sx / sy); e.hi = 32'(sx % sy);
            end
         end
         default: e.lo = 32'h0BADC0DE;
      endcase
      e.nf = e.lo[31];
      e.zf = (e.lo == 32'd0);
      return e;
   endfunction

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 7))
         0: return 32'h00000000;
         1: return 32'h00000001;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'h7FFFFFFF;
         5: return 32'($urandom_range(0, 15));
         default: return 32'($urandom);
      endcase
   endfunction

   // Present one operation; called and returns on a falling edge
   task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
      exp_t e;
      int   n;
      op = o; a = x; b = y; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 300) begin
         @(negedge CLK);
         n++;
      end
      if (!in_ready) begin
         checks++; failures++;
         $display("FAIL accept_timeout op=%0d in_ready=%b required=1", o, in_ready);
         in_valid = 1'b0;
         return;
      end
      e = model(o, x, y);
      e.acc_cyc = cyc + 1;
      q.push_back(e);
      @(negedge CLK);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((q.size() != 0 || out_valid || !in_ready) && n < 500) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 500) begin
         checks++; failures++;
         $display("FAIL idle_timeout pending=%0d out_valid=%b required pending=0", q.size(), out_valid);
      end
   endtask

   // Consumer: out_ready changes just after the rising edge
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge CLK);
         #1;
         case (rdy_mode)
            1:       out_ready = 1'b0;
            2:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 9) < 7);
         endcase
      end
   end

   // Monitor: compare each newly presented result against the queue head
   initial begin
      exp_t e;
      int   lat;
      forever begin
         @(negedge CLK);
         if (RST) begin
            checked = 1'b0;
         end else begin
            if (out_valid && !checked) begin
               checked = 1'b1;
               if (q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_result lo=%h hi=%h required none", out_lo, out_hi);
               end else begin
                  e   = q.pop_front();
                  lat = cyc - e.acc_cyc + 1;
                  chk($sformatf("op%0d_lo", e.op), 64'(out_lo), 64'(e.lo));
                  chk($sformatf("op%0d_hi", e.op), 64'(out_hi), 64'(e.hi));
                  chk($sformatf("op%0d_flags_nzvd", e.op), 64'({nf, zf, vf, dz}),
                      64'({e.nf, e.zf, e.vf, e.dz}));
                  checks++;
                  if (lat < e.lat_min || lat > e.lat_max) begin
                     failures++;
                     $display("FAIL op%0d_latency got=%0d required=%0d..%0d", e.op, lat, e.lat_min, e.lat_max);
                  end
               end
            end
            if (out_valid && out_ready) checked = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t        be;
      logic [31:0] x, y;
      int          n;
      RST = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_in_ready",  64'(in_ready),  64'd1);
      chk("reset_out_lo",    64'(out_lo),    64'd0);
      chk("reset_out_hi",    64'(out_hi),    64'd0);
      chk("reset_flags",     64'({nf, zf, vf, dz}), 64'd0);

      // Directed cases
      issue(OP_ADD,  32'h7FFFFFFF, 32'd1);
      issue(OP_MUL,  32'hFFFFFFFD, 32'd7);
      issue(OP_DIV,  32'hFFFFFFF9, 32'd2);
      issue(OP_DIVU, 32'd7,        32'd0);
      issue(OP_DIV,  32'h80000000, 32'hFFFFFFFF);
      issue(OP_SUB,  32'h80000000, 32'd1);
      issue(OP_SLL,  32'h00000003, 32'd33);
      issue(OP_SRA,  32'h80000000, 32'd31);
      issue(OP_SLT,  32'hFFFFFFFF, 32'd0);
      issue(OP_SLTU, 32'hFFFFFFFF, 32'd0);
      issue(5'd20,   32'd1,        32'd2);
      issue(OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      issue(OP_MUL,  32'h12345678, 32'd0);

      // Backpressure: held MULU result, extra request ignored
      wait_idle();
      rdy_mode = 1;
      x = 32'($urandom); y = 32'($urandom) | 32'h80000000;
      be = model(OP_MULU, x, y);
      issue(OP_MULU, x, y);
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge CLK);
         n++;
      end
      chk("bp_result_valid", 64'(out_valid), 64'd1);
      op = OP_ADD; a = 32'd1; b = 32'd1; in_valid = 1'b1;
      repeat (5) begin
         @(negedge CLK);
         chk("bp_hold_lo",       64'(out_lo),    64'(be.lo));
         chk("bp_hold_hi",       64'(out_hi),    64'(be.hi));
         chk("bp_hold_in_ready", 64'(in_ready),  64'd0);
         chk("bp_hold_valid",    64'(out_valid), 64'd1);
      end
      in_valid = 1'b0;
      rdy_mode = 2;
      @(negedge CLK);
      @(negedge CLK);
      chk("bp_release_in_ready", 64'(in_ready),  64'd1);
      chk("bp_release_valid",    64'(out_valid), 64'd0);
      rdy_mode = 0;

      // Reset during multiply iteration 10 drops the operation
      wait_idle();
      issue(OP_MUL, 32'hFFFFFFFD, 32'h80000007);
      repeat (9) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      chk("midop_reset_valid",    64'(out_valid), 64'd0);
      chk("midop_reset_in_ready", 64'(in_ready),  64'd1);
      if (q.size() != 0) void'(q.pop_back());
      RST = 1'b0;
      issue(OP_ADD, 32'd2, 32'd3);

      // Random traffic
      for (int i = 0; i < 80; i++) begin
         issue(5'($urandom_range(0, 17)), rnd_operand(), rnd_operand());
         repeat ($urandom_range(0, 2)) @(negedge CLK);
      end

      wait_idle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
